gpio_pad_ctrl: RTL and testbench

GPIO_PAD_CTRL -- requirements
Module: gpio_pad_ctrl

---
 rtl/gpio_pad_ctrl.sv | 137 +++++++++++++
 tb/tb_gpio_pad_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_pad_ctrl.sv
// Memory-mapped GPIO block: output/direction/edge-interrupt registers, input synchronizer
// and a per-bit HIZ/ARM/DRIVE sequencer so pad data settles before the buffer drives.
module gpio_pad_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             iomem_valid,
  output logic             iomem_ready,
  input  logic [4:0]       iomem_addr,
  input  logic [3:0]       iomem_wstrb,
  input  logic [31:0]      iomem_wdata,
  output logic [31:0]      iomem_rdata,
  output logic [WIDTH-1:0] pad_a,
  output logic [WIDTH-1:0] pad_en_n,
  input  logic [WIDTH-1:0] pad_y,
  output logic             irq
);

  typedef enum logic [1:0] {StHiz, StArm, StDrive} pad_st_e;

  logic [WIDTH-1:0] out_q, dir_q, dir_d, irq_en_q, stat_q, stat_d, edge_q;
  logic [WIDTH-1:0] sync1_q, sync2_q, sync3_q, hit, clr;
  logic [WIDTH-1:0] en_n_q;
  logic [2:0]       prime_q;
  logic             ready_q, irq_q;
  logic [31:0]      rdata_q, rd_val, mask;
  logic [2:0]       sel;
  logic             access, wr, rd;
  logic             unused_addr;
  pad_st_e          st_q [WIDTH];
  pad_st_e          st_d [WIDTH];

  function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old,
                                             input logic [31:0] m, input logic [31:0] d);
    return WIDTH'((32'(old) & ~m) | (d & m));
  endfunction

  assign unused_addr = ^iomem_addr[1:0];
  assign sel         = iomem_addr[4:2];
  // A new access starts only when the previous completion pulse has ended.
  assign access      = iomem_valid & ~ready_q;
  assign wr          = access & (|iomem_wstrb);
  assign rd          = access & ~(|iomem_wstrb);
  assign mask        = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                        {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
  assign clr         = (wr && sel == 3'd4) ? WIDTH'(iomem_wdata & mask) : '0;

  // Edges are ignored until the third stage holds a genuine sample after reset.
  assign hit = {WIDTH{prime_q[2]}} &
               ((sync2_q & ~sync3_q & edge_q) | (~sync2_q & sync3_q & ~edge_q));

  always_comb begin
    dir_d  = (wr && sel == 3'd1) ? merge(dir_q, mask, iomem_wdata) : dir_q;
    stat_d = (stat_q & ~clr) | hit;
  end

  always_comb begin
    rd_val = '0;
    case (sel)
      3'd0:    rd_val = 32'(out_q);
      3'd1:    rd_val = 32'(dir_q);
      3'd2:    rd_val = 32'(sync2_q);
      3'd3:    rd_val = 32'(irq_en_q);
      3'd4:    rd_val = 32'(stat_q);
      3'd5:    rd_val = 32'(edge_q);
      default: rd_val = '0;
    endcase
  end

  // FSM steps on the incoming DIR value so a disable takes effect the cycle DIR updates.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      st_d[i] = st_q[i];
      unique case (st_q[i])
        StHiz:   if (dir_d[i]) st_d[i] = StArm;
        StArm:   st_d[i] = dir_d[i] ? StDrive : StHiz;
        StDrive: if (!dir_d[i]) st_d[i] = StHiz;
        default: st_d[i] = StHiz;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < WIDTH; i++) st_q[i] <= StHiz;
      en_n_q <= '1;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        st_q[i]   <= st_d[i];
        en_n_q[i] <= (st_d[i] != StDrive);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_q    <= '0;
      dir_q    <= '0;
      irq_en_q <= '0;
      stat_q   <= '0;
      edge_q   <= '0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      sync3_q  <= '0;
      prime_q  <= '0;
      ready_q  <= 1'b0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      ready_q <= access;
      rdata_q <= rd ? rd_val : '0;
      if (wr) begin
        case (sel)
          3'd0:    out_q    <= merge(out_q, mask, iomem_wdata);
          3'd3:    irq_en_q <= merge(irq_en_q, mask, iomem_wdata);
          3'd5:    edge_q   <= merge(edge_q, mask, iomem_wdata);
          default: ;
        endcase
      end
      dir_q   <= dir_d;
      stat_q  <= stat_d;
      irq_q   <= |(stat_q & irq_en_q);
      sync1_q <= pad_y;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      prime_q <= {prime_q[1:0], 1'b1};
    end
  end

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign pad_a       = out_q;
  assign pad_en_n    = en_n_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Directed bench for gpio_pad_ctrl: register-map vector table plus hand sequences for
// output-enable sequencing, edge interrupts, bus pacing and reset behaviour.
module tb_gpio_pad_ctrl;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         iomem_valid = 1'b0;
  logic         iomem_ready;
  logic [4:0]   iomem_addr = '0;
  logic [3:0]   iomem_wstrb = '0;
  logic [31:0]  iomem_wdata = '0;
  logic [31:0]  iomem_rdata;
  logic [W-1:0] pad_a, pad_en_n;
  logic [W-1:0] pad_y = '0;
  logic         irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[$];

  gpio_pad_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_addr  (iomem_addr),
    .iomem_wstrb (iomem_wstrb),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .pad_a       (pad_a),
    .pad_en_n    (pad_en_n),
    .pad_y       (pad_y),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Starts an access on a negedge once ready is low; returns 1 time unit after ready rises.
  task automatic bus(input logic [4:0] a, input logic [3:0] s, input logic [31:0] d,
                     output logic [31:0] r);
    int n = 0;
    int g = 0;
    @(negedge clk);
    while (iomem_ready && g < 4) begin
      @(negedge clk);
      g++;
    end
    iomem_valid = 1'b1;
    iomem_addr  = a;
    iomem_wstrb = s;
    iomem_wdata = d;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!iomem_ready && n < 8);
    r = iomem_rdata;
    iomem_valid = 1'b0;
    iomem_wstrb = '0;
    check("ready_latency", 32'(n), 32'd1);
  endtask

  task automatic wr(input logic [4:0] a, input logic [3:0] s, input logic [31:0] d);
    logic [31:0] r;
    bus(a, s, d, r);
  endtask

  task automatic rd(input string name, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] r;
    bus(a, 4'h0, 32'h0, r);
    check(name, r, exp);
  endtask

  task automatic add(input logic [4:0] a, input logic [3:0] s, input logic [31:0] d,
                     input logic [31:0] e);
    vec_t v;
    v.addr = a; v.wstrb = s; v.wdata = d; v.exp = e;
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] r;

    // Register-map table: wstrb==0 entries are reads compared against exp.
    add(5'h00, 4'h0, 32'h0, 32'h0);
    add(5'h04, 4'h0, 32'h0, 32'h0);
    add(5'h08, 4'h0, 32'h0, 32'h0);
    add(5'h0C, 4'h0, 32'h0, 32'h0);
    add(5'h10, 4'h0, 32'h0, 32'h0);
    add(5'h14, 4'h0, 32'h0, 32'h0);
    add(5'h18, 4'h0, 32'h0, 32'h0);
    add(5'h1C, 4'h0, 32'h0, 32'h0);
    add(5'h00, 4'hF, 32'h0000_00A5, 32'h0);
    add(5'h00, 4'h0, 32'h0, 32'h0000_00A5);
    add(5'h00, 4'hF, 32'h0, 32'h0);
    add(5'h00, 4'h2, 32'hFFFF_FFFF, 32'h0);
    add(5'h00, 4'h0, 32'h0, 32'h0000_FF00);
    add(5'h00, 4'h1, 32'h1234_5678, 32'h0);
    add(5'h00, 4'h0, 32'h0, 32'h0000_FF78);
    add(5'h0C, 4'hF, 32'hFFFF_FFFF, 32'h0);
    add(5'h0D, 4'h0, 32'h0, 32'h0000_FFFF);
    add(5'h18, 4'hF, 32'hFFFF_FFFF, 32'h0);
    add(5'h18, 4'h0, 32'h0, 32'h0);
    add(5'h1C, 4'h0, 32'h0, 32'h0);
    add(5'h08, 4'hF, 32'hFFFF_FFFF, 32'h0);
    add(5'h08, 4'h0, 32'h0, 32'h0);
    add(5'h14, 4'hC, 32'hFFFF_FFFF, 32'h0);
    add(5'h14, 4'h0, 32'h0, 32'h0);
    add(5'h0C, 4'hF, 32'h0, 32'h0);
    add(5'h0C, 4'h0, 32'h0, 32'h0);
    add(5'h10, 4'hF, 32'hFFFF_FFFF, 32'h0);
    add(5'h10, 4'h0, 32'h0, 32'h0);

    // Reset state, while asserted and after release
    repeat (3) @(negedge clk);
    check("rst_en_n", 32'(pad_en_n), 32'h0000_FFFF);
    check("rst_pad_a", 32'(pad_a), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_ready", 32'(iomem_ready), 32'h0);
    check("rst_rdata", iomem_rdata, 32'h0);
    resetn = 1'b1;
    tick(1);
    check("post_rst_en_n", 32'(pad_en_n), 32'h0000_FFFF);
    check("post_rst_irq", 32'(irq), 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      bus(vecs[i].addr, vecs[i].wstrb, vecs[i].wdata, r);
      if (vecs[i].wstrb == 4'h0) check($sformatf("vec%0d", i), r, vecs[i].exp);
    end

    // Output data first, then ARM for one cycle, then DRIVE
    wr(5'h00, 4'hF, 32'h0000_00A5);
    check("pad_a_out", 32'(pad_a), 32'h0000_00A5);
    wr(5'h04, 4'hF, 32'h0000_00FF);
    check("arm_hiz", 32'(pad_en_n), 32'h0000_FFFF);
    tick(1);
    check("drive", 32'(pad_en_n), 32'h0000_FF00);
    check("drive_pad_a", 32'(pad_a), 32'h0000_00A5);
    wr(5'h04, 4'hF, 32'h0);
    check("dir_off_same_cycle", 32'(pad_en_n), 32'h0000_FFFF);

    // 1->0->1 must re-enter ARM
    wr(5'h04, 4'hF, 32'h0000_00FF);
    tick(2);
    check("drive2", 32'(pad_en_n), 32'h0000_FF00);
    wr(5'h04, 4'hF, 32'h0);
    check("off2", 32'(pad_en_n), 32'h0000_FFFF);
    wr(5'h04, 4'hF, 32'h0000_00FF);
    check("rearm", 32'(pad_en_n), 32'h0000_FFFF);
    tick(1);
    check("redrive", 32'(pad_en_n), 32'h0000_FF00);
    wr(5'h04, 4'hF, 32'h0);

    // valid held high: completions are spaced by at least one idle cycle
    repeat (2) @(negedge clk);
    iomem_valid = 1'b1;
    iomem_addr  = 5'h00;
    iomem_wstrb = 4'h0;
    tick(1);
    check("hold_ready1", 32'(iomem_ready), 32'h1);
    check("hold_rdata", iomem_rdata, 32'h0000_00A5);
    tick(1);
    check("hold_gap", 32'(iomem_ready), 32'h0);
    tick(1);
    check("hold_ready2", 32'(iomem_ready), 32'h1);
    iomem_valid = 1'b0;
    tick(1);
    check("hold_end", 32'(iomem_ready), 32'h0);

    // Rising edge on bit 3 with interrupt enabled
    wr(5'h14, 4'hF, 32'h0000_0008);
    wr(5'h0C, 4'hF, 32'h0000_0008);
    wr(5'h10, 4'hF, 32'h0000_FFFF);
    @(negedge clk);
    pad_y[3] = 1'b1;
    tick(3);
    check("irq_before", 32'(irq), 32'h0);
    tick(1);
    check("irq_after", 32'(irq), 32'h1);
    rd("stat_edge", 5'h10, 32'h0000_0008);
    rd("in_bit3", 5'h08, 32'h0000_0008);
    wr(5'h10, 4'hF, 32'h0000_0008);
    tick(1);
    check("irq_cleared", 32'(irq), 32'h0);
    rd("stat_cleared", 5'h10, 32'h0);

    // Bit 5: falling edge selected, not enabled, not an output
    @(negedge clk);
    pad_y[5] = 1'b1;
    tick(4);
    rd("stat_rise_ignored", 5'h10, 32'h0);
    @(negedge clk);
    pad_y[5] = 1'b0;
    tick(4);
    rd("stat_fall_set", 5'h10, 32'h0000_0020);
    check("irq_masked", 32'(irq), 32'h0);

    // New edge in the same cycle as its W1C keeps the bit set
    wr(5'h10, 4'hF, 32'h0000_FFFF);
    @(negedge clk);
    pad_y[3] = 1'b0;
    tick(4);
    rd("stat_pre_coincide", 5'h10, 32'h0);
    @(negedge clk);
    pad_y[3] = 1'b1;
    @(negedge clk);
    wr(5'h10, 4'hF, 32'h0000_0008);
    rd("stat_coincide", 5'h10, 32'h0000_0008);
    check("irq_coincide", 32'(irq), 32'h1);

    // Asynchronous toggles at arbitrary offsets from the clock
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #($urandom_range(0, 9));
      pad_y[0] = ~pad_y[0];
    end
    tick(3);
    bus(5'h08, 4'h0, 32'h0, r);
    check("in_known", 32'($isunknown(r)), 32'h0);
    check("in_async", r, 32'(pad_y));

    // Reset in the middle of an access; pad high across release
    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_addr  = 5'h00;
    iomem_wstrb = 4'hF;
    iomem_wdata = 32'h0000_FFFF;
    #2;
    resetn = 1'b0;
    @(posedge clk);
    #1;
    check("abort_ready", 32'(iomem_ready), 32'h0);
    check("abort_irq", 32'(irq), 32'h0);
    check("abort_en_n", 32'(pad_en_n), 32'h0000_FFFF);
    check("abort_pad_a", 32'(pad_a), 32'h0);
    check("abort_rdata", iomem_rdata, 32'h0);
    iomem_valid = 1'b0;
    iomem_wstrb = '0;
    pad_y = 16'h0010;
    @(negedge clk);
    resetn = 1'b1;
    wr(5'h14, 4'hF, 32'h0000_FFFF);
    tick(6);
    rd("no_spurious_edge", 5'h10, 32'h0);
    rd("abort_no_commit", 5'h00, 32'h0);
    rd("in_after_reset", 5'h08, 32'h0000_0010);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
